weight_loader: RTL and testbench

//  Streams 32-bit weight words (IEEE-754 single) from an external valid/ready source into the

---
 rtl/lvg_pkg.sv | 18 +
 rtl/wl_checksum.sv | 23 ++
 rtl/weight_loader.sv | 128 ++++++++++++
 tb/tb_weight_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvg_pkg.sv
// Shared widths and loader state encoding for the weight path (loader and head).
package lvg_pkg;

    localparam int LVG_DATA_W  = 32;
    localparam int LVG_WADDR_W = 4;

    typedef enum logic [1:0] {
        WL_IDLE = 2'd0,
        WL_LOAD = 2'd1,
        WL_FIN  = 2'd2
    } wl_state_e;

    // Weight memory addresses wrap modulo its depth.
    function automatic logic [LVG_WADDR_W-1:0] wl_next_addr(input logic [LVG_WADDR_W-1:0] a);
        return a + LVG_WADDR_W'(1);
    endfunction

endpackage

// File: rtl/wl_checksum.sv
// Wrapping sum of every word written to weight memory since the last accepted start.
module wl_checksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Streams weight words from a valid/ready source into weight memory, then kicks head.
// Optional WEIGHT_LOADER_CHECKSUM_EN adds a checksum output of the words written.
module weight_loader
    import lvg_pkg::*;
#(
    parameter int DATA_W = LVG_DATA_W,
    parameter int ADDR_W = LVG_WADDR_W,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              head_start,
    output logic [1:0]        dbg_state
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,output logic [DATA_W-1:0] checksum
`endif
);

    // Stream handshake: a beat transfers on any rising clk edge where s_valid && s_ready;
    // s_ready depends only on state, never on s_valid.
    wl_state_e         state, next_state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [CNT_W-1:0]  remaining;
    logic              start_acc;
    logic              accept;
    logic              last_beat;
    logic              end_load;

    // busy also covers the done cycle, so a start there is ignored like any other busy start.
    assign start_acc = start && (state == WL_IDLE) && !busy;
    assign s_ready   = (state == WL_LOAD);
    assign accept    = s_valid && s_ready;
    assign last_beat = (remaining == CNT_W'(1));
    assign end_load  = accept && (last_beat || s_last);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WL_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            WL_IDLE: begin
                if (start_acc) begin
                    next_state = (count != '0) ? WL_LOAD : WL_FIN;
                end
            end
            WL_LOAD: begin
                if (end_load) begin
                    next_state = WL_FIN;
                end
            end
            WL_FIN:  next_state = WL_IDLE;
            default: next_state = WL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ptr   <= '0;
            remaining  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            head_start <= 1'b0;
        end else begin
            wr_en      <= accept;
            // FIN follows the final write cycle, so done lands one cycle after it.
            done       <= (state == WL_FIN);
            head_start <= (state == WL_FIN) && !err;

            if (start_acc) begin
                addr_ptr  <= base_addr;
                remaining <= count;
                err       <= 1'b0;
                busy      <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end

            if (accept) begin
                wr_addr   <= addr_ptr;
                wr_data   <= s_data;
                addr_ptr  <= wl_next_addr(addr_ptr);
                remaining <= remaining - CNT_W'(1);
                // s_last must coincide exactly with the final counted word.
                if (s_last != last_beat) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    wl_checksum #(
        .DATA_W(DATA_W)
    ) u_checksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_acc),
        .add_en  (wr_en),
        .add_data(wr_data),
        .sum     (checksum)
    );
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: directed table, hand-written reset/checksum sequences, random loads.
module tb_weight_loader;
    import lvg_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int CW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] count;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          head_start;
    logic [1:0]    dbg_state;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    weight_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .head_start(head_start),
        .dbg_state (dbg_state)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,.checksum (checksum)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] got_q[$];
    logic [DW-1:0]    tb_mem[16];
    int n_checks = 0;
    int n_errors = 0;

    int          n_wr, n_done, n_rdy, n_stray_hs;
    int          last_wr_cyc, done_cyc;
    logic        done_err, done_hs, done_busy, prev_done, busy_after, err_after;
    logic [DW-1:0] done_sum;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_monitor();
        n_wr = 0; n_done = 0; n_rdy = 0; n_stray_hs = 0;
        last_wr_cyc = -1; done_cyc = -1; prev_done = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                got_q.push_back({wr_addr, wr_data});
                tb_mem[wr_addr] = wr_data;
                last_wr_cyc = cyc;
                n_wr++;
            end
            if (s_ready) n_rdy++;
            if (head_start && !done) n_stray_hs++;
            if (prev_done) begin
                busy_after = busy;
                err_after  = err;
            end
            if (done) begin
                n_done++;
                done_cyc  = cyc;
                done_err  = err;
                done_hs   = head_start;
                done_busy = busy;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                done_sum  = checksum;
`else
                done_sum  = '0;
`endif
            end
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at #1 after a posedge.
    task automatic send_word(input logic [DW-1:0] d, input bit last, input int gap, output bit ok);
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        ok = 1'b0;
        for (int g = 0; g < 64 && !ok; g++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Reference model: word i lands at (base+i) mod 16; sending stops at an early s_last.
    task automatic run_load(input string tag, input int base, input int cnt, input int last_pos,
                            input int gap_max, input bit use_fixed, input logic [DW-1:0] fdata,
                            input bit poke, input int exp_writes, input bit exp_err, input bit exp_hs);
        int            n_send;
        int            start_cyc;
        bit            ok;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_sum;
        logic [AW+DW-1:0] e, g;
        clear_monitor();
        exp_sum = '0;
        n_send = (last_pos > 0 && last_pos < cnt) ? last_pos : cnt;

        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(base); count = CW'(cnt);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = AW'($urandom); count = CW'($urandom);
        check({tag, " err_clear"}, 64'(err), 64'(0));
        check({tag, " busy_set"}, 64'(busy), 64'(1));

        for (int i = 0; i < n_send; i++) begin
            d = use_fixed ? fdata : DW'($urandom);
            exp_q.push_back({AW'((base + i) % 16), d});
            exp_sum = exp_sum + d;
            if (poke && i == 1) begin
                start = 1'b1; base_addr = AW'(base + 7); count = CW'(3);
            end
            send_word(d, (i + 1 == last_pos), $urandom_range(0, gap_max), ok);
            start = 1'b0;
            if (!ok) begin
                check({tag, " beat_timeout"}, 64'(0), 64'(1));
                break;
            end
        end

        for (int w = 0; w < 100 && n_done == 0; w++) @(negedge clk);
        if (n_done == 0) check({tag, " done_timeout"}, 64'(0), 64'(1));
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        check({tag, " done_count"}, 64'(n_done), 64'(1));
        check({tag, " writes"}, 64'(n_wr), 64'(exp_writes));
        check({tag, " err"}, 64'(done_err), 64'(exp_err));
        check({tag, " head_start"}, 64'(done_hs), 64'(exp_hs));
        check({tag, " stray_head_start"}, 64'(n_stray_hs), 64'(0));
        check({tag, " busy_at_done"}, 64'(done_busy), 64'(1));
        check({tag, " busy_after_done"}, 64'(busy_after), 64'(0));
        check({tag, " err_sticky"}, 64'(err_after), 64'(exp_err));
        if (exp_writes > 0)
            check({tag, " done_latency"}, 64'(done_cyc - last_wr_cyc), 64'(1));
        else begin
            check({tag, " done_latency"}, 64'(done_cyc - start_cyc), 64'(2));
            check({tag, " no_ready"}, 64'(n_rdy), 64'(0));
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " write"}, 64'(g), 64'(e));
        end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check({tag, " checksum"}, 64'(done_sum), 64'(exp_sum));
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       tag;
        int          base;
        int          cnt;
        int          last_pos;
        int          gap_max;
        bit          use_fixed;
        logic [31:0] fdata;
        bit          poke;
        int          exp_writes;
        bit          exp_err;
        bit          exp_hs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int cnt, lp, mode, exp_w;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = '0;

        vecs[0] = '{"full16",    0, 16, 16, 0, 1, 32'h3f80_0000, 0, 16, 0, 1};
        vecs[1] = '{"wrap_gaps", 14, 4,  4, 3, 0, 32'h0,         1,  4, 0, 1};
        vecs[2] = '{"count0",    5,  0,  0, 0, 0, 32'h0,         0,  0, 0, 1};
        vecs[3] = '{"early_last",3,  4,  2, 1, 0, 32'h0,         0,  2, 1, 0};
        vecs[4] = '{"no_last",   9,  3,  0, 1, 0, 32'h0,         0,  3, 1, 0};
        vecs[5] = '{"over16",    10, 20, 20, 1, 0, 32'h0,        0, 20, 0, 1};
        vecs[6] = '{"count1",    15, 1,  1, 0, 0, 32'h0,         0,  1, 0, 1};
        vecs[7] = '{"last_first",2,  5,  1, 0, 0, 32'h0,         0,  1, 1, 0};

        repeat (3) @(negedge clk);
        check("reset_state", 64'(dbg_state), 64'(WL_IDLE));
        check("reset_outs", 64'({s_ready, wr_en, busy, done, err, head_start}), 64'(0));
        check("reset_wr", 64'({wr_addr, wr_data}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            run_load(vecs[v].tag, vecs[v].base, vecs[v].cnt, vecs[v].last_pos, vecs[v].gap_max,
                     vecs[v].use_fixed, vecs[v].fdata, vecs[v].poke,
                     vecs[v].exp_writes, vecs[v].exp_err, vecs[v].exp_hs);
            if (v == 0) begin
                for (int a = 0; a < 16; a++)
                    check("full16_mem", 64'(tb_mem[a]), 64'(32'h3f80_0000));
            end
        end

        // Reset in the middle of an 8-word load.
        clear_monitor();
        start = 1'b1; base_addr = 4'd4; count = 5'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_word(DW'($urandom), 1'b0, 0, ok);
            check("rst_pre_beat", 64'(ok), 64'(1));
        end
        #2 rst = 1'b1;
        #1;
        check("rst_async_state", 64'(dbg_state), 64'(WL_IDLE));
        check("rst_async_outs", 64'({s_ready, wr_en, busy, done, err, head_start}), 64'(0));
        check("rst_async_wr", 64'({wr_addr, wr_data}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        run_load("after_rst", 6, 5, 5, 2, 0, 32'h0, 0, 5, 0, 1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        run_load("cksum4", 0, 4, 4, 0, 1, 32'h3f80_0000, 1, 4, 0, 1);
        check("cksum4_value", 64'(done_sum), 64'(32'hfe00_0000));
`endif

        // Random loads against the reference model.
        for (int r = 0; r < 14; r++) begin
            cnt  = $urandom_range(1, 20);
            mode = $urandom_range(0, 3);
            lp   = (mode == 1) ? 0 : (mode == 2) ? $urandom_range(1, cnt) : cnt;
            exp_w = (lp > 0 && lp < cnt) ? lp : cnt;
            run_load("random", $urandom_range(0, 15), cnt, lp, $urandom_range(0, 3), 0, 32'h0,
                     $urandom_range(0, 1) == 1 && exp_w >= 2, exp_w, lp != cnt, lp == cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
